// File: rtl/axis_cobs_decode_arb_pkg.sv
// Shared COBS definitions: frame delimiter, arbiter state encodings and the skid entry layout.
// Used by the COBS encoder, the decoder and the decoder input arbiter.
package axis_cobs_decode_arb_pkg;

    localparam logic [7:0] COBS_DELIM = 8'h00;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    // flush marks the forced terminator so its downstream acceptance can be reported
    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       flush;
    } skid_entry_t;

    function automatic logic is_frame_end(input logic [7:0] data, input logic last);
        return (data == COBS_DELIM) || last;
    endfunction

endpackage

// File: rtl/axis_cobs_decode_arb_rr.sv
// Combinational round-robin pick: first requester at or after the pointer.
module axis_cobs_decode_arb_rr #(
    parameter int S_COUNT    = 4,
    parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0]    req,
    input  logic [CL_S_COUNT-1:0] ptr,
    output logic                  gnt_valid,
    output logic [CL_S_COUNT-1:0] gnt_idx
);

    logic [CL_S_COUNT-1:0] cand_idx;

    // Scan from the farthest offset down so the nearest requester is written last and wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            cand_idx = CL_S_COUNT'((int'(ptr) + i) % S_COUNT);
            if (req[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/axis_cobs_decode_arb.sv
// Frame-granular round-robin arbiter feeding several COBS-encoded AXIS channels into one shared
// decoder, with a stall timeout that force-terminates a stuck frame and a two-entry output skid.
module axis_cobs_decode_arb
    import axis_cobs_decode_arb_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_COUNT*8-1:0]    s_axis_tdata,
    input  logic [S_COUNT-1:0]      s_axis_tvalid,
    input  logic [S_COUNT-1:0]      s_axis_tlast,
    input  logic [S_COUNT-1:0]      s_axis_tuser,
    output logic [S_COUNT-1:0]      s_axis_tready,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic [CL_S_COUNT-1:0]   m_axis_tid,
    output logic                    grant_valid,
    output logic [CL_S_COUNT-1:0]   grant_encoded,
    output logic                    stat_timeout
);

    localparam int STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [STALL_W-1:0]    STALL_LIMIT = STALL_W'(TIMEOUT);
    localparam logic [CL_S_COUNT-1:0] LAST_CH     = CL_S_COUNT'(S_COUNT - 1);

    logic [1:0]            state_q, state_d;
    logic [CL_S_COUNT-1:0] ptr_q, ptr_d, grant_q, grant_d, next_ptr;
    logic                  grant_valid_q, grant_valid_d;
    logic [STALL_W-1:0]    stall_q, stall_d;
    logic                  rst_done_q, rst_done_d;
    logic                  ready_q, ready_d;
    skid_entry_t           out_q, out_d, tmp_q, tmp_d, in_entry;
    logic                  out_valid_q, out_valid_d, tmp_valid_q, tmp_valid_d;
    logic [CL_S_COUNT-1:0] out_tid_q, out_tid_d, tmp_tid_q, tmp_tid_d;
    logic                  in_valid;
    logic                  rr_valid;
    logic [CL_S_COUNT-1:0] rr_idx;
    logic [S_COUNT-1:0][7:0] ch_data;

    assign ch_data  = s_axis_tdata;
    assign next_ptr = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;

    axis_cobs_decode_arb_rr #(
        .S_COUNT    (S_COUNT),
        .CL_S_COUNT (CL_S_COUNT)
    ) u_rr (
        .req       (s_axis_tvalid),
        .ptr       (ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // rst_done_q holds off arbitration for one edge after reset release
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        stall_d       = stall_q;
        rst_done_d    = 1'b1;
        in_valid      = 1'b0;
        in_entry      = '{data: ch_data[grant_q], last: s_axis_tlast[grant_q],
                          user: s_axis_tuser[grant_q], flush: 1'b0};
        case (state_q)
            ST_IDLE: begin
                if (rst_done_q && rr_valid) begin
                    grant_d       = rr_idx;
                    grant_valid_d = 1'b1;
                    stall_d       = '0;
                    state_d       = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                in_valid = s_axis_tvalid[grant_q] && ready_q;
                if (in_valid) begin
                    stall_d = '0;
                    if (is_frame_end(in_entry.data, in_entry.last)) begin
                        state_d       = ST_IDLE;
                        grant_valid_d = 1'b0;
                        ptr_d         = next_ptr;
                    end
                end else if (TIMEOUT > 0 && !s_axis_tvalid[grant_q]) begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + 1'b1;
                    end
                    if (stall_d == STALL_LIMIT) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                in_entry = '{data: COBS_DELIM, last: 1'b1, user: 1'b1, flush: 1'b1};
                in_valid = ready_q;
                if (ready_q) begin
                    state_d       = ST_IDLE;
                    grant_valid_d = 1'b0;
                    ptr_d         = next_ptr;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered ready lets a byte land in tmp while the output register is stalled
    always_comb begin
        out_d       = out_q;
        out_tid_d   = out_tid_q;
        out_valid_d = out_valid_q;
        tmp_d       = tmp_q;
        tmp_tid_d   = tmp_tid_q;
        tmp_valid_d = tmp_valid_q;
        ready_d     = !tmp_valid_q && (!out_valid_q || m_axis_tready);
        if (ready_q) begin
            if (m_axis_tready || !out_valid_q) begin
                out_valid_d = in_valid;
                out_d       = in_entry;
                out_tid_d   = grant_q;
            end else begin
                tmp_valid_d = in_valid;
                tmp_d       = in_entry;
                tmp_tid_d   = grant_q;
            end
        end else if (m_axis_tready) begin
            out_valid_d = tmp_valid_q;
            out_d       = tmp_q;
            out_tid_d   = tmp_tid_q;
            tmp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            stall_q       <= '0;
            rst_done_q    <= 1'b0;
            ready_q       <= 1'b0;
            out_q         <= '0;
            out_tid_q     <= '0;
            out_valid_q   <= 1'b0;
            tmp_q         <= '0;
            tmp_tid_q     <= '0;
            tmp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            stall_q       <= stall_d;
            rst_done_q    <= rst_done_d;
            ready_q       <= ready_d;
            out_q         <= out_d;
            out_tid_q     <= out_tid_d;
            out_valid_q   <= out_valid_d;
            tmp_q         <= tmp_d;
            tmp_tid_q     <= tmp_tid_d;
            tmp_valid_q   <= tmp_valid_d;
        end
    end

    always_comb begin
        s_axis_tready = '0;
        if (state_q == ST_ACTIVE && !rst) begin
            s_axis_tready[grant_q] = ready_q;
        end
    end

    assign m_axis_tdata  = out_q.data;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tuser  = out_q.user;
    assign m_axis_tid    = out_tid_q;
    assign m_axis_tvalid = out_valid_q && !rst;
    assign grant_valid   = grant_valid_q && !rst;
    assign grant_encoded = grant_q;
    assign stat_timeout  = out_valid_q && m_axis_tready && out_q.flush && !rst;

endmodule

// File: tb/tb_axis_cobs_decode_arb.sv
// Directed bench for axis_cobs_decode_arb: queued channel sources, an output monitor and
// hand-computed expectations for arbitration order, timeout flush, backpressure and reset.
module tb_axis_cobs_decode_arb;

    typedef struct {
        logic [1:0] tid;
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       stat;
        int         cyc;
    } mon_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0][7:0] src_data;
    logic [31:0]     s_axis_tdata;
    logic [3:0]      s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic [1:0]      m_axis_tid, grant_encoded;
    logic            grant_valid, stat_timeout;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         overlap_cnt = 0;
    int         stat_cnt = 0;
    int         unstable_cnt = 0;
    logic       mt_mode = 1'b0;
    logic [9:0] src_q [4][$];
    mon_t       mon_q [$];
    logic [1:0] grant_log [$];

    assign s_axis_tdata = src_data;

    axis_cobs_decode_arb #(
        .S_COUNT (4),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .m_axis_tid    (m_axis_tid),
        .grant_valid   (grant_valid),
        .grant_encoded (grant_encoded),
        .stat_timeout  (stat_timeout)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Sources and monitor: sample on the falling edge, update drives 1ns after the rising edge
    initial begin
        logic [3:0]  hs;
        logic        prev_stall;
        logic [11:0] prev_word;
        logic        gv_prev;
        logic [3:0]  pat;
        pat           = 4'b1001;
        prev_stall    = 1'b0;
        prev_word     = '0;
        gv_prev       = 1'b0;
        src_data      = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            hs = s_axis_tvalid & s_axis_tready;
            if ($countones(s_axis_tready) > 1) overlap_cnt++;
            if (stat_timeout) stat_cnt++;
            if (prev_stall && !(m_axis_tvalid &&
                {m_axis_tid, m_axis_tlast, m_axis_tuser, m_axis_tdata} == prev_word))
                unstable_cnt++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready)
                mon_q.push_back('{m_axis_tid, m_axis_tdata, m_axis_tlast, m_axis_tuser,
                                  stat_timeout, cyc});
            if (grant_valid && !gv_prev) grant_log.push_back(grant_encoded);
            gv_prev = grant_valid;
            @(posedge clk);
            #1;
            for (int ch = 0; ch < 4; ch++) begin
                if (hs[2'(ch)] && src_q[ch].size() > 0) void'(src_q[ch].pop_front());
                s_axis_tvalid[2'(ch)] = (src_q[ch].size() > 0);
                if (src_q[ch].size() > 0) begin
                    {s_axis_tuser[2'(ch)], s_axis_tlast[2'(ch)], src_data[2'(ch)]} = src_q[ch][0];
                end
            end
            m_axis_tready = mt_mode ? pat[2'(cyc % 4)] : 1'b1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input int ch, input logic [7:0] d, input logic l, input logic u);
        src_q[ch].push_back({u, l, d});
    endtask

    task automatic clear_all();
        for (int ch = 0; ch < 4; ch++) src_q[ch].delete();
        mon_q.delete();
        grant_log.delete();
        overlap_cnt  = 0;
        stat_cnt     = 0;
        unstable_cnt = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_output(tag, {s_axis_tready, m_axis_tvalid, grant_valid, stat_timeout}, 32'h0);
    endtask

    task automatic wait_count(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (mon_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_output(tag, mon_q.size(), n);
    endtask

    task automatic check_item(input string tag, input int idx, input logic [1:0] tid,
                              input logic [7:0] d, input logic l, input logic u);
        if (idx < mon_q.size())
            check_output(tag, {mon_q[idx].tid, mon_q[idx].last, mon_q[idx].user, mon_q[idx].data},
                         {tid, l, u, d});
        else
            check_output({tag, "_missing"}, mon_q.size(), idx + 1);
    endtask

    task automatic check_grant(input string tag, input int idx, input logic [1:0] exp);
        if (idx < grant_log.size()) check_output(tag, grant_log[idx], exp);
        else check_output({tag, "_missing"}, grant_log.size(), idx + 1);
    endtask

    initial begin
        logic [7:0] b;

        // Two simultaneous frames; also covers reset values and first-grant latency
        push_byte(0, 8'h03, 0, 0); push_byte(0, 8'h11, 0, 0);
        push_byte(0, 8'h22, 0, 0); push_byte(0, 8'h00, 0, 0);
        push_byte(2, 8'h03, 0, 0); push_byte(2, 8'h11, 0, 0);
        push_byte(2, 8'h22, 0, 0); push_byte(2, 8'h00, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_outputs");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("grant_not_first_edge", grant_valid, 1'b0);
        @(negedge clk);
        check_output("grant_second_edge", {grant_valid, grant_encoded}, {1'b1, 2'd0});
        wait_count(8, 100, "t1_count");
        check_item("t1_b0", 0, 2'd0, 8'h03, 0, 0);
        check_item("t1_b1", 1, 2'd0, 8'h11, 0, 0);
        check_item("t1_b2", 2, 2'd0, 8'h22, 0, 0);
        check_item("t1_b3", 3, 2'd0, 8'h00, 0, 0);
        check_item("t1_b4", 4, 2'd2, 8'h03, 0, 0);
        check_item("t1_b7", 7, 2'd2, 8'h00, 0, 0);
        if (mon_q.size() >= 5) check_output("t1_gap", mon_q[4].cyc - mon_q[3].cyc, 2);

        // All channels continuously valid for eight frames
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < 4; ch++) begin
                push_byte(ch, 8'h02, 0, 0);
                push_byte(ch, 8'(16 * ch + r + 1), 0, 0);
                push_byte(ch, 8'h00, 0, 0);
            end
        end
        wait_count(24, 400, "t2_count");
        for (int f = 0; f < 8; f++) begin
            check_grant($sformatf("t2_grant%0d", f), f, 2'(f % 4));
            check_item($sformatf("t2_frame%0d_b1", f), f * 3 + 1, 2'(f % 4),
                       8'(16 * (f % 4) + (f / 4) + 1), 0, 0);
            check_item($sformatf("t2_frame%0d_b2", f), f * 3 + 2, 2'(f % 4), 8'h00, 0, 0);
        end
        check_output("t2_tready_overlap", overlap_cnt, 0);

        // Stall timeout on channel 1 forces a terminator, then the pointer moves to 2
        apply_reset();
        push_byte(1, 8'h05, 0, 0);
        push_byte(1, 8'hAA, 0, 0);
        wait_count(3, 100, "t3_count");
        check_item("t3_b0", 0, 2'd1, 8'h05, 0, 0);
        check_item("t3_b1", 1, 2'd1, 8'hAA, 0, 0);
        check_item("t3_flush", 2, 2'd1, 8'h00, 1, 1);
        if (mon_q.size() >= 3) begin
            check_output("t3_flush_delay", mon_q[2].cyc - mon_q[1].cyc, 17);
            check_output("t3_stat_on_flush", mon_q[2].stat, 1'b1);
        end
        push_byte(0, 8'h01, 0, 0); push_byte(0, 8'h00, 0, 0);
        push_byte(2, 8'h01, 0, 0); push_byte(2, 8'h00, 0, 0);
        wait_count(7, 100, "t3_next_count");
        check_output("t3_stat_pulses", stat_cnt, 1);
        check_grant("t3_next_grant", 1, 2'd2);
        check_grant("t3_after_grant", 2, 2'd0);
        check_item("t3_next_b0", 3, 2'd2, 8'h01, 0, 0);

        // 254-byte frame under a 1,0,0,1 ready pattern
        apply_reset();
        mt_mode = 1'b1;
        for (int i = 0; i < 253; i++) push_byte(0, 8'(i + 1), 0, 0);
        push_byte(0, 8'h00, 0, 0);
        wait_count(254, 3000, "t4_count");
        for (int i = 0; i < 254; i++) begin
            b = (i < 253) ? 8'(i + 1) : 8'h00;
            check_item($sformatf("t4_b%0d", i), i, 2'd0, b, 0, 0);
        end
        check_output("t4_hold_stable", unstable_cnt, 0);
        mt_mode = 1'b0;

        // Reset in the middle of a channel 3 frame that follows a channel 2 frame
        apply_reset();
        push_byte(2, 8'h01, 0, 0); push_byte(2, 8'h00, 0, 0);
        push_byte(3, 8'h05, 0, 0); push_byte(3, 8'h01, 0, 0); push_byte(3, 8'h02, 0, 0);
        push_byte(3, 8'h03, 0, 0); push_byte(3, 8'h04, 0, 0); push_byte(3, 8'h00, 0, 0);
        wait_count(4, 100, "t5_pre_count");
        check_grant("t5_pre_grant", 1, 2'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_all();
        @(negedge clk);
        check_quiet("t5_in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("t5_after_reset");
        push_byte(1, 8'h02, 0, 0); push_byte(1, 8'h77, 0, 0); push_byte(1, 8'h00, 0, 0);
        push_byte(3, 8'h02, 0, 0); push_byte(3, 8'h88, 0, 0); push_byte(3, 8'h00, 0, 0);
        wait_count(6, 100, "t5_count");
        repeat (20) @(negedge clk);
        check_output("t5_no_extra_bytes", mon_q.size(), 6);
        check_grant("t5_ptr_restart", 0, 2'd1);
        check_item("t5_b0", 0, 2'd1, 8'h02, 0, 0);
        check_item("t5_b1", 1, 2'd1, 8'h77, 0, 0);
        check_item("t5_b2", 2, 2'd1, 8'h00, 0, 0);
        check_item("t5_b3", 3, 2'd3, 8'h02, 0, 0);
        check_item("t5_b4", 4, 2'd3, 8'h88, 0, 0);

        // Frame ended by tlast on a non-zero byte carrying tuser
        apply_reset();
        push_byte(0, 8'h02, 0, 0);
        push_byte(0, 8'h01, 1, 1);
        wait_count(2, 100, "t6_count");
        check_item("t6_b0", 0, 2'd0, 8'h02, 0, 0);
        check_item("t6_b1", 1, 2'd0, 8'h01, 1, 1);
        repeat (3) @(negedge clk);
        check_output("t6_grant_released", grant_valid, 1'b0);
        check_output("t6_no_stat", stat_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_cobs_decode_arb.md
AXIS_COBS_DECODE_ARB -- requirements
Module: axis_cobs_decode_arb

Interface
REQ-001 Parameter S_COUNT, default 4, SHALL set the number of COBS-encoded input channels (legal range 2..16).
REQ-002 Parameter TIMEOUT, default 1024, SHALL set the stall-timeout in clk cycles; 0 disables the timeout.
REQ-003 Parameter CL_S_COUNT, default $clog2(S_COUNT), SHALL set the tid and grant index width.
REQ-004 clk  input  1  clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_axis_tdata  input  S_COUNT*8  per-channel encoded byte; channel n is bits [8n+7:8n].
REQ-007 s_axis_tvalid, s_axis_tlast, s_axis_tuser  input  S_COUNT each  per-channel AXIS sideband.
REQ-008 s_axis_tready  output  S_COUNT  per-channel ready; at most one bit SHALL be high in any cycle.
REQ-009 m_axis_tdata  output  8  byte to the shared COBS decoder.
REQ-010 m_axis_tvalid, m_axis_tlast, m_axis_tuser  output  1 each  AXIS sideband to the decoder.
REQ-011 m_axis_tready  input  1  decoder ready.
REQ-012 m_axis_tid  output  CL_S_COUNT  source channel of the current byte.
REQ-013 grant_valid  output  1  a channel currently owns the decoder.
REQ-014 grant_encoded  output  CL_S_COUNT  index of the owning channel.
REQ-015 stat_timeout  output  1  single-cycle pulse when a forced frame termination is accepted downstream.

Function
REQ-016 The block SHALL have states IDLE, ACTIVE and FLUSH.
REQ-017 In IDLE, with any s_axis_tvalid bit high, the block SHALL grant the first requesting channel at or after the round-robin pointer, register grant_valid=1 and grant_encoded, and enter ACTIVE the next cycle.
REQ-018 The round-robin pointer SHALL be 0 after reset and SHALL become (k+1) mod S_COUNT when a frame from channel k terminates, whether normally or by timeout.
REQ-019 In ACTIVE, s_axis_tready[k] SHALL follow the output-buffer early-ready; all other tready bits SHALL be 0.
REQ-020 Accepted bytes SHALL appear on m_axis one cycle later, with tdata, tlast and tuser unchanged and tid=k.
REQ-021 Sustained throughput within a frame SHALL be one byte per cycle.
REQ-022 A frame SHALL end on acceptance of a byte with tdata==0x00 or tlast==1. The block SHALL then clear grant_valid and return to IDLE, giving exactly one idle arbitration cycle between frames.
REQ-023 A leading 0x00 accepted in ACTIVE SHALL end the frame (one-byte frame); it SHALL be forwarded, not dropped.
REQ-024 With TIMEOUT>0, a stall counter SHALL increment on each ACTIVE cycle where s_axis_tvalid[k]=0, and SHALL clear on every accepted byte and on entry to ACTIVE.
REQ-025 When the stall counter reaches TIMEOUT, the block SHALL enter FLUSH.
REQ-026 In FLUSH, all s_axis_tready bits SHALL be 0. The block SHALL present tdata=0x00, tuser=1, tlast=1, tid=k.
REQ-027 On acceptance of the FLUSH byte, the block SHALL pulse stat_timeout, advance the pointer and return to IDLE.
REQ-028 If the stall counter reaches TIMEOUT in the same cycle a byte from k is accepted, the accepted byte SHALL win: the counter clears and FLUSH is not entered.
REQ-029 The output SHALL be a registered two-entry skid stage. Early-ready = temp empty AND (output not valid OR m_axis_tready); no byte SHALL be lost or duplicated under any m_axis_tready pattern.
REQ-030 m_axis_tvalid SHALL NOT deassert while m_axis_tready is low, and m_axis data and sideband SHALL remain stable during that time.
REQ-031 The stall counter width SHALL be $clog2(TIMEOUT+1). The counter SHALL saturate and never wrap.

Reset
REQ-032 During rst the block SHALL enter IDLE with pointer=0 and stall counter=0.
REQ-033 During rst, s_axis_tready, m_axis_tvalid, grant_valid and stat_timeout SHALL all be 0, and skid contents SHALL be invalidated.
REQ-034 Reset mid-frame SHALL discard any partially forwarded frame without emitting a terminating byte.
REQ-035 The first grant after reset release SHALL be no earlier than the second clk edge.

Structure
REQ-036 The COBS delimiter constant (0x00) and state encodings SHALL live in a shared cobs package used by the encoder, decoder and this block.
REQ-037 Round-robin selection SHALL be one combinational sub-module, axis_cobs_decode_arb_rr (inputs: request vector, pointer; outputs: grant valid, grant index).
REQ-038 The skid stage SHALL be inline.

Verification
REQ-039 Channels 0 and 2 each send frame {03 11 22 00} simultaneously, m_axis_tready=1 -> channel 0 frame then channel 2 frame on m_axis with tid 0 then 2, and a 1-cycle gap between frames.
REQ-040 All 4 channels are continuously valid for 8 frames -> grants follow 0,1,2,3,0,1,2,3 and no tready overlap occurs.
REQ-041 TIMEOUT=16; channel 1 sends {05 AA} then stalls -> after 16 stall cycles m_axis carries 00 with tuser=1, tlast=1, tid=1, stat_timeout pulses once, and channel 2 is granted next.
REQ-042 m_axis_tready toggles 1,0,0,1 repeatedly during a 254-byte frame -> output byte sequence identical to input and m_axis data held stable while stalled.
REQ-043 rst asserted for 1 cycle mid-frame on channel 3 -> all outputs 0 next cycle, pointer restarts at 0, and the next frame is forwarded cleanly.
REQ-044 A frame ends on tlast=1 with tdata=0x01 and tuser=1 -> the byte is forwarded with tlast=1 and tuser=1, and the grant is released.
